// File: rtl/my_mc_ctrl.sv
// my_mc_ctrl -- multi-cycle control unit for a small RV32-style datapath.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and drives the datapath strobes for each state. The decode outputs
// (ALU_Control, ImmSel, ALUSrc_B, MemtoReg) come combinationally from
// inst_field, which the external IR holds stable after IRWrite.
//
// Optional feature: define MY_MC_CTRL_TIMEOUT_EN to bound memory waits.
// In that build, TIMEOUT_CYCLES consecutive request-high cycles without an
// ack send the FSM to TRAP and set the sticky err flag. In the default build
// waits are unbounded and err is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   inst_field   current instruction word
//   imem_req/ack instruction fetch handshake
//   dmem_req/we/ack  data access handshake (we: 1 store, 0 load)
//   IRWrite, PCWrite, RegWrite, Jump, Branch  datapath strobes
//   ALU_Control  ALU operation; ImmSel immediate format
//   MemtoReg     write-back source; ALUSrc_B  immediate as ALU operand B
//   state_out    current state encoding
//   illegal      sticky illegal-instruction flag; err  sticky timeout flag
module my_mc_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_field,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [2:0]  ALU_Control,
  output logic [1:0]  ImmSel,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrc_B,
  output logic        Jump,
  output logic        Branch,
  output logic        RegWrite,
  output logic [2:0]  state_out,
  output logic        illegal,
  output logic        err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_nxt;
  logic   illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal;
  logic       f3_ok, legal;
  logic [2:0] alu_dec;
  logic [1:0] imm_dec;
  logic [1:0] m2r_dec;
  logic       srcb_dec;

  logic       mem_req_raw, mem_ack_raw;
  logic       tmo_fire;

  // Only opcode, funct3 and funct7[5] steer control; the rest of the word
  // belongs to the datapath.
  logic unused_inst;
  assign unused_inst = ^{inst_field[31], inst_field[29:15], inst_field[11:7]};

  assign opcode    = inst_field[6:0];
  assign funct3    = inst_field[14:12];
  assign funct7_b5 = inst_field[30];

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_jal = (opcode == OP_JAL);

  // Instruction decode
  always_comb begin
    alu_dec  = ALU_ADD;
    f3_ok    = 1'b1;
    imm_dec  = 2'b00;
    m2r_dec  = 2'b00;
    srcb_dec = 1'b0;
    if (is_r || is_i) begin
      unique case (funct3)
        3'b000:  alu_dec = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_dec = ALU_AND;
        3'b110:  alu_dec = ALU_OR;
        3'b010:  alu_dec = ALU_SLT;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = ALU_SRL;
        default: f3_ok   = 1'b0;   // funct3 001 and 011 are illegal
      endcase
    end else if (is_beq) begin
      alu_dec = ALU_SUB;
    end
    if (is_sw)  imm_dec = 2'b01;
    if (is_beq) imm_dec = 2'b10;
    if (is_jal) imm_dec = 2'b11;
    if (is_lw)  m2r_dec = 2'b01;
    if (is_jal) m2r_dec = 2'b10;
    srcb_dec = is_i || is_lw || is_sw;
  end

  assign legal = ((is_r || is_i) && f3_ok) || is_lw || is_sw || is_beq || is_jal;

  // The request/ack pair that belongs to the current wait state; acks seen
  // outside FETCH/MEM are ignored.
  assign mem_req_raw = (state_q == FETCH) || (state_q == MEM);
  assign mem_ack_raw = ((state_q == FETCH) && imem_ack) ||
                       ((state_q == MEM)   && dmem_ack);

`ifdef MY_MC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Fires in the last allowed wait cycle, so TRAP is entered after exactly
  // TIMEOUT_CYCLES request-high cycles without an ack.
  assign tmo_fire = mem_req_raw && !mem_ack_raw &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (mem_req_raw && !mem_ack_raw && (state_nxt == state_q))
        wait_cnt_q <= wait_cnt_q + 1'b1;
      else
        wait_cnt_q <= '0;
      if (tmo_fire)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo_fire       = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if ((state_q == DECODE) && !legal)
        illegal_q <= 1'b1;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_nxt = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    Jump      = 1'b0;
    Branch    = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          IRWrite   = 1'b1;
          state_nxt = DECODE;
        end else if (tmo_fire) begin
          state_nxt = TRAP;
        end
      end
      DECODE: state_nxt = legal ? EXEC : TRAP;
      EXEC: begin
        if (is_beq) begin
          Branch    = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = FETCH;
        end else if (is_jal) begin
          Jump      = 1'b1;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ack) begin
          if (is_sw) begin
            PCWrite   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end else if (tmo_fire) begin
          state_nxt = TRAP;
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase

    // While reset is held every output reads zero, even though the state
    // register already sits in FETCH.
    if (!rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      Jump     = 1'b0;
      Branch   = 1'b0;
    end
  end

  assign ALU_Control = rst ? alu_dec  : 3'b000;
  assign ImmSel      = rst ? imm_dec  : 2'b00;
  assign MemtoReg    = rst ? m2r_dec  : 2'b00;
  assign ALUSrc_B    = rst ? srcb_dec : 1'b0;
  assign state_out   = state_q;
  assign illegal     = illegal_q;

endmodule
